// File: rtl/config_responder_pkg.sv
// Shared types and constants for the push-button configuration responder:
// FSM encoding, push bit indices, BCD field limits and a BCD legality helper.
package config_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT   = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   localparam int NUM_PB   = 5;
   localparam int PB_CFG   = 0;
   localparam int PB_UP    = 1;
   localparam int PB_DOWN  = 2;
   localparam int PB_RIGHT = 3;
   localparam int PB_LEFT  = 4;

   localparam logic [1:0] CUR_SEC = 2'd0;
   localparam logic [1:0] CUR_MIN = 2'd1;
   localparam logic [1:0] CUR_HR  = 2'd2;

   localparam logic [7:0] MAX_SEC = 8'h59;
   localparam logic [7:0] MAX_HR  = 8'h23;

   // A field is usable only if both digits are decimal and it lies within its range.
   function automatic logic bcd_legal(input logic [7:0] value, input logic [7:0] limit);
      return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= limit);
   endfunction

endpackage

// File: rtl/config_responder_bcd_updown.sv
// Combinational BCD up/down step with wrap at 00 and at the field limit.
// Illegal input values collapse to 00 so a garbage RTC field is sanitised on first edit.
module bcd_updown
   import config_responder_pkg::*;
(
   input  logic [7:0] value_i,
   input  logic [7:0] limit_i,
   input  logic       up_i,
   output logic [7:0] next_o
);

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      next_o = 8'h00;
      if (!bcd_legal(value_i, limit_i)) begin
         next_o = 8'h00;
      end else if (up_i) begin
         if (value_i == limit_i)           next_o = 8'h00;
         else if (value_i[3:0] == 4'd9)    next_o = {value_i[7:4] + 4'd1, 4'd0};
         else                              next_o = {value_i[7:4], value_i[3:0] + 4'd1};
      end else begin
         if (value_i == 8'h00)             next_o = limit_i;
         else if (value_i[3:0] == 4'd0)    next_o = {value_i[7:4] - 4'd1, 4'd9};
         else                              next_o = {value_i[7:4], value_i[3:0] - 4'd1};
      end
   end

endmodule

// File: rtl/config_responder.sv
// Consumes push-button requests one per cycle (cfg > up > down > right > left),
// acknowledges each with a listo pulse, and runs the BCD time editor and RTC commit handshake.
module config_responder
   import config_responder_pkg::*;
#(
   parameter int ACK_LEN = 2
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_PB-1:0] push_in,
   output logic [NUM_PB-1:0] listo_out,
   input  logic [7:0]        rtc_hr,
   input  logic [7:0]        rtc_min,
   input  logic [7:0]        rtc_sec,
   output logic              cfg_active,
   output logic [1:0]        cursor,
   output logic [7:0]        hr_out,
   output logic [7:0]        min_out,
   output logic [7:0]        sec_out,
   output logic              wr_req,
   input  logic              wr_ack
);

   localparam int CW = $clog2(ACK_LEN + 1);

   state_e            state_q, state_d;
   logic [NUM_PB-1:0] armed, pulsing, accept, eligible, grant;
   logic [1:0]        cursor_q, cursor_d;
   logic [7:0]        hr_q, hr_d, min_q, min_d, sec_q, sec_d;
   logic [7:0]        fld_val, fld_lim, fld_next;

   for (genvar i = 0; i < NUM_PB; i++) begin : g_pb
      logic          arm_q;
      logic [CW-1:0] cnt_q;

      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      always_ff @(posedge clk) begin
         if (!rst) begin
            arm_q <= 1'b1;
            cnt_q <= '0;
         end else if (grant[i]) begin
            arm_q <= 1'b0;
            cnt_q <= CW'(ACK_LEN);
         end else begin
            if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            if (!push_in[i] && cnt_q == '0) arm_q <= 1'b1;
         end
      end

      assign armed[i]   = arm_q;
      assign pulsing[i] = (cnt_q != '0);
   end

   always_comb begin
      accept = '1;
      if (state_q == ST_COMMIT) accept[PB_CFG] = 1'b0;
   end

   assign eligible = push_in & armed & accept;
   // Isolate the lowest set bit: bit 0 (cfg) carries the highest priority.
   assign grant    = eligible & (~eligible + NUM_PB'(1));

   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (grant[PB_CFG]) state_d = ST_EDIT;
         ST_EDIT:   if (grant[PB_CFG]) state_d = ST_COMMIT;
         ST_COMMIT: if (wr_ack)        state_d = ST_IDLE;
         default:                      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cfg_active = (state_q == ST_EDIT);
      wr_req     = (state_q == ST_COMMIT);
   end

   always_comb begin
      case (cursor_q)
         CUR_MIN: fld_val = min_q;
         CUR_HR:  fld_val = hr_q;
         default: fld_val = sec_q;
      endcase
      fld_lim = (cursor_q == CUR_HR) ? MAX_HR : MAX_SEC;
   end

   bcd_updown u_bcd (
      .value_i (fld_val),
      .limit_i (fld_lim),
      .up_i    (grant[PB_UP]),
      .next_o  (fld_next)
   );

   always_comb begin
      cursor_d = cursor_q;
      hr_d     = hr_q;
      min_d    = min_q;
      sec_d    = sec_q;
      case (state_q)
         ST_IDLE: begin
            hr_d  = rtc_hr;
            min_d = rtc_min;
            sec_d = rtc_sec;
            if (grant[PB_CFG]) cursor_d = CUR_SEC;
         end
         ST_EDIT: begin
            if (grant[PB_UP] || grant[PB_DOWN]) begin
               case (cursor_q)
                  CUR_MIN: min_d = fld_next;
                  CUR_HR:  hr_d  = fld_next;
                  default: sec_d = fld_next;
               endcase
            end
            if (grant[PB_RIGHT]) cursor_d = (cursor_q == CUR_HR)  ? CUR_SEC : cursor_q + 2'd1;
            if (grant[PB_LEFT])  cursor_d = (cursor_q == CUR_SEC) ? CUR_HR  : cursor_q - 2'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cursor_q <= CUR_SEC;
         hr_q     <= 8'h00;
         min_q    <= 8'h00;
         sec_q    <= 8'h00;
      end else begin
         cursor_q <= cursor_d;
         hr_q     <= hr_d;
         min_q    <= min_d;
         sec_q    <= sec_d;
      end
   end

   assign listo_out = pulsing;
   assign cursor    = cursor_q;
   assign hr_out    = hr_q;
   assign min_out   = min_q;
   assign sec_out   = sec_q;

endmodule

// File: tb/tb_config_responder.sv
// Scoreboard bench for config_responder: each press queues its expected post-consume snapshot,
// and a monitor compares it whenever a listo bit rises.
module tb_config_responder;
   import config_responder_pkg::*;

   typedef struct packed {
      logic [4:0]  ack;
      logic [23:0] hms;
      logic [1:0]  cur;
      logic        act;
      logic        wr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] push_in;
   logic [4:0] listo_out;
   logic [7:0] rtc_hr, rtc_min, rtc_sec;
   logic       cfg_active;
   logic [1:0] cursor;
   logic [7:0] hr_out, min_out, sec_out;
   logic       wr_req;
   logic       wr_ack;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   logic [4:0] prev_listo = '0;

   config_responder #(.ACK_LEN(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .push_in    (push_in),
      .listo_out  (listo_out),
      .rtc_hr     (rtc_hr),
      .rtc_min    (rtc_min),
      .rtc_sec    (rtc_sec),
      .cfg_active (cfg_active),
      .cursor     (cursor),
      .hr_out     (hr_out),
      .min_out    (min_out),
      .sec_out    (sec_out),
      .wr_req     (wr_req),
      .wr_ack     (wr_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input int b, input logic [23:0] hms, input logic [1:0] cur,
                               input logic act, input logic wr);
      exp_t e;
      e.ack = 5'b00001 << b;
      e.hms = hms;
      e.cur = cur;
      e.act = act;
      e.wr  = wr;
      return e;
   endfunction

   always @(negedge clk) begin
      logic [4:0] rise;
      exp_t       e;
      if (rst === 1'b1) begin
         rise = listo_out & ~prev_listo;
         if (rise != 5'b0) begin
            if (sb.size() == 0) begin
               check("unexpected_ack", 32'(rise), 32'h0);
            end else begin
               e = sb.pop_front();
               check("ack_bit",    32'(rise),                       32'(e.ack));
               check("buffer",     32'({hr_out, min_out, sec_out}), 32'(e.hms));
               check("cursor",     32'(cursor),                     32'(e.cur));
               check("cfg_active", 32'(cfg_active),                 32'(e.act));
               check("wr_req",     32'(wr_req),                     32'(e.wr));
            end
         end
      end
      prev_listo = listo_out;
   end

   task automatic wait_for(input int b, input logic lvl);
      int n = 0;
      while (listo_out[b] !== lvl && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) check($sformatf("wait_listo%0d", b), 32'(listo_out[b]), 32'(lvl));
   endtask

   task automatic press(input int b, input exp_t e);
      sb.push_back(e);
      push_in[b] = 1'b1;
      wait_for(b, 1'b1);
      push_in[b] = 1'b0;
      wait_for(b, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   hi_cnt;
      int   lo_cnt;
      logic [2:0] pend;
      rst     = 1'b0;
      push_in = 5'h1f;
      wr_ack  = 1'b0;
      {rtc_hr, rtc_min, rtc_sec} = 24'h235959;

      // Reset with every push held high.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_listo",  32'(listo_out),                  32'h0);
      check("rst_wr_req", 32'(wr_req),                     32'h0);
      check("rst_active", 32'(cfg_active),                 32'h0);
      check("rst_cursor", 32'(cursor),                     32'h0);
      check("rst_buffer", 32'({hr_out, min_out, sec_out}), 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      sb.push_back(mk(PB_CFG, 24'h235959, 2'd0, 1'b1, 1'b0));
      @(posedge clk); #1;
      push_in = 5'h00;
      @(negedge clk); check("rst_cfg_pulse_c1", 32'(listo_out), 32'h01);
      @(negedge clk); check("rst_cfg_pulse_c2", 32'(listo_out), 32'h01);
      @(negedge clk); check("rst_cfg_pulse_c3", 32'(listo_out), 32'h00);
      @(posedge clk); #1;

      // Edit wrap on every field, cursor wraps both ways, hr 00 - 1 = 23.
      press(PB_UP,    mk(PB_UP,    24'h235900, 2'd0, 1'b1, 1'b0));
      press(PB_RIGHT, mk(PB_RIGHT, 24'h235900, 2'd1, 1'b1, 1'b0));
      press(PB_UP,    mk(PB_UP,    24'h230000, 2'd1, 1'b1, 1'b0));
      press(PB_RIGHT, mk(PB_RIGHT, 24'h230000, 2'd2, 1'b1, 1'b0));
      press(PB_UP,    mk(PB_UP,    24'h000000, 2'd2, 1'b1, 1'b0));
      press(PB_RIGHT, mk(PB_RIGHT, 24'h000000, 2'd0, 1'b1, 1'b0));
      press(PB_LEFT,  mk(PB_LEFT,  24'h000000, 2'd2, 1'b1, 1'b0));
      press(PB_DOWN,  mk(PB_DOWN,  24'h230000, 2'd2, 1'b1, 1'b0));

      // Commit: cfg held during COMMIT stays pending, other pushes are discarded.
      press(PB_CFG,   mk(PB_CFG,   24'h230000, 2'd2, 1'b0, 1'b1));
      push_in[PB_CFG] = 1'b1;
      press(PB_UP,    mk(PB_UP,    24'h230000, 2'd2, 1'b0, 1'b1));
      {rtc_hr, rtc_min, rtc_sec} = 24'h121005;
      hi_cnt = 0;
      lo_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (listo_out[PB_CFG]) hi_cnt++;
         if (!wr_req) lo_cnt++;
      end
      check("commit_cfg_pending", 32'(hi_cnt), 32'h0);
      check("commit_wr_req_held", 32'(lo_cnt), 32'h0);
      check("commit_buffer_frozen", 32'({hr_out, min_out, sec_out}), 32'h230000);
      sb.push_back(mk(PB_CFG, 24'h121005, 2'd0, 1'b1, 1'b0));
      @(posedge clk); #1;
      wr_ack = 1'b1;
      @(posedge clk); #1;
      wr_ack = 1'b0;
      @(negedge clk);
      check("ack_wr_req_drop", 32'(wr_req),     32'h0);
      check("ack_idle",        32'(cfg_active), 32'h0);
      wait_for(PB_CFG, 1'b1);
      push_in[PB_CFG] = 1'b0;
      wait_for(PB_CFG, 1'b0);
      @(posedge clk); #1;

      // BCD borrow on minutes: 10 -> 09 -> 08.
      press(PB_RIGHT, mk(PB_RIGHT, 24'h121005, 2'd1, 1'b1, 1'b0));
      press(PB_DOWN,  mk(PB_DOWN,  24'h120905, 2'd1, 1'b1, 1'b0));
      press(PB_DOWN,  mk(PB_DOWN,  24'h120805, 2'd1, 1'b1, 1'b0));
      press(PB_RIGHT, mk(PB_RIGHT, 24'h120805, 2'd2, 1'b1, 1'b0));

      // Simultaneous up/down/right, each held until acknowledged.
      sb.push_back(mk(PB_UP,    24'h130805, 2'd2, 1'b1, 1'b0));
      sb.push_back(mk(PB_DOWN,  24'h120805, 2'd2, 1'b1, 1'b0));
      sb.push_back(mk(PB_RIGHT, 24'h120805, 2'd0, 1'b1, 1'b0));
      push_in = 5'b01110;
      pend    = 3'b111;
      for (int i = 0; i < 20 && pend != 3'b000; i++) begin
         @(posedge clk); #1;
         for (int b = 0; b < 3; b++) begin
            if (pend[b] && listo_out[b + 1]) begin
               push_in[b + 1] = 1'b0;
               pend[b] = 1'b0;
            end
         end
      end
      check("simul_all_acked", 32'(pend), 32'h0);
      push_in = 5'h00;
      repeat (4) @(posedge clk);
      #1;

      // Held up yields one increment; a fresh press yields a second.
      sb.push_back(mk(PB_UP, 24'h120806, 2'd0, 1'b1, 1'b0));
      push_in[PB_UP] = 1'b1;
      wait_for(PB_UP, 1'b1);
      wait_for(PB_UP, 1'b0);
      repeat (50) @(posedge clk);
      #1;
      check("hold_single_inc", 32'(sec_out), 32'h06);
      push_in[PB_UP] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      press(PB_UP, mk(PB_UP, 24'h120807, 2'd0, 1'b1, 1'b0));

      // Reset in the middle of COMMIT.
      press(PB_CFG, mk(PB_CFG, 24'h120807, 2'd0, 1'b0, 1'b1));
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_wr_req", 32'(wr_req),                     32'h0);
      check("midrst_active", 32'(cfg_active),                 32'h0);
      check("midrst_buffer", 32'({hr_out, min_out, sec_out}), 32'h0);
      check("midrst_listo",  32'(listo_out),                  32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
